// File: rtl/mul_div_if.sv
// mul_div_if: operand/handshake bundle between the datapath and the multiply/divide unit.
interface mul_div_if #(parameter int WIDTH = 32);
    logic Start;
    logic [1:0] Op;
    logic [WIDTH-1:0] OperandA;
    logic [WIDTH-1:0] OperandB;
    logic HiWrite;
    logic LoWrite;
    logic [WIDTH-1:0] HiLoData;
    logic Busy;
    logic Done;
    logic DivByZero;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;
    modport master (
        output Start, Op, OperandA, OperandB, HiWrite, LoWrite, HiLoData,
        input Busy, Done, DivByZero, Hi, Lo
    );
    modport slave (
        input Start, Op, OperandA, OperandB, HiWrite, LoWrite, HiLoData,
        output Busy, Done, DivByZero, Hi, Lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MIPS MULT/MULTU/DIV/DIVU with private HI/LO registers.
module mul_div_unit #(parameter int WIDTH = 32) (
    input logic Clk,
    input logic Reset,
    mul_div_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [1:0] IDLE = 2'd0, ITER = 2'd1, FIX = 2'd2;
    logic [1:0] state;
    logic [CW-1:0] count;
    logic isDiv, negA, negB, divZero;
    logic [WIDTH-1:0] operand, hiReg, loReg;
    logic [2*WIDTH-1:0] work;
    logic aNeg, bNeg;
    logic [WIDTH-1:0] magA, magB;
    logic [WIDTH:0] mulSum, diff;
    logic [2*WIDTH:0] shifted;
    logic [2*WIDTH-1:0] mulNext, divNext, prod;
    logic [WIDTH-1:0] quot, rem, hiFix, loFix;
    always_comb begin
        aNeg = bus.Op[0] & bus.OperandA[WIDTH-1];
        bNeg = bus.Op[0] & bus.OperandB[WIDTH-1];
        magA = aNeg ? -bus.OperandA : bus.OperandA;
        magB = bNeg ? -bus.OperandB : bus.OperandB;
        // Shift-add: low half holds the multiplier and drains as the product fills in.
        mulSum = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, operand} : '0);
        mulNext = {mulSum, work[WIDTH-1:1]};
        // Restoring divide: keep the shifted remainder when the trial subtract goes negative.
        shifted = {work, 1'b0};
        diff = shifted[2*WIDTH:WIDTH] - {1'b0, operand};
        divNext = diff[WIDTH] ? shifted[2*WIDTH-1:0] : {diff[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
        prod = (negA ^ negB) ? -work : work;
        quot = work[WIDTH-1:0];
        rem = work[2*WIDTH-1:WIDTH];
        hiFix = isDiv ? (negA ? -rem : rem) : prod[2*WIDTH-1:WIDTH];
        loFix = isDiv ? (divZero ? '1 : ((negA ^ negB) ? -quot : quot)) : prod[WIDTH-1:0];
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            count <= '0;
            isDiv <= 1'b0;
            negA <= 1'b0;
            negB <= 1'b0;
            divZero <= 1'b0;
            operand <= '0;
            work <= '0;
            hiReg <= '0;
            loReg <= '0;
            bus.Done <= 1'b0;
            bus.DivByZero <= 1'b0;
        end else begin
            bus.Done <= state == FIX;
            bus.DivByZero <= state == FIX && divZero;
            if (state == IDLE) begin
                if (bus.HiWrite) hiReg <= bus.HiLoData;
                if (bus.LoWrite) loReg <= bus.HiLoData;
                if (bus.Start) begin
                    state <= ITER;
                    count <= '0;
                    isDiv <= bus.Op[1];
                    negA <= aNeg;
                    negB <= bNeg;
                    divZero <= bus.Op[1] && bus.OperandB == '0;
                    operand <= bus.Op[1] ? magB : magA;
                    work <= {{WIDTH{1'b0}}, bus.Op[1] ? magA : magB};
                end
            end else if (state == ITER) begin
                work <= isDiv ? divNext : mulNext;
                count <= count + 1'b1;
                if (count == LAST) state <= FIX;
            end else begin
                hiReg <= hiFix;
                loReg <= loFix;
                state <= IDLE;
            end
        end
    end
    assign bus.Busy = state != IDLE;
    assign bus.Hi = hiReg;
    assign bus.Lo = loReg;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors for mul_div_unit with hand-computed results.
module tb_mul_div_unit;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    int checkCount = 0;
    int errorCount = 0;
    mul_div_if #(.WIDTH(32)) bus ();
    mul_div_unit #(.WIDTH(32)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Starts at the current negedge and returns at the negedge where Done is seen.
    task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busyCycles, output logic dbz);
        bus.Start = 1'b1;
        bus.Op = op;
        bus.OperandA = a;
        bus.OperandB = b;
        lat = 0;
        busyCycles = 0;
        dbz = 1'b0;
        while (lat < 100) begin
            @(negedge Clk);
            bus.Start = 1'b0;
            lat++;
            if (bus.Busy) busyCycles++;
            if (bus.Done) begin
                dbz = bus.DivByZero;
                break;
            end
        end
    endtask

    task automatic checkOp(input string tag, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] expHi, input logic [31:0] expLo,
                           input logic expDbz);
        int lat, busyCycles;
        logic dbz;
        runOp(op, a, b, lat, busyCycles, dbz);
        check({tag, " latency"}, 64'(lat), 64'd34);
        check({tag, " hilo"}, {bus.Hi, bus.Lo}, {expHi, expLo});
        check({tag, " dbz"}, 64'(dbz), 64'(expDbz));
    endtask

    initial begin
        int lat, busyCycles, doneSeen;
        logic dbz;
        bus.Start = 1'b0;
        bus.Op = 2'b00;
        bus.OperandA = '0;
        bus.OperandB = '0;
        bus.HiWrite = 1'b0;
        bus.LoWrite = 1'b0;
        bus.HiLoData = '0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        check("reset busy", 64'(bus.Busy), 64'd0);
        check("reset done", 64'(bus.Done), 64'd0);
        check("reset hilo", {bus.Hi, bus.Lo}, 64'd0);

        checkOp("multu max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        runOp(2'b01, 32'hFFFFFFFD, 32'd7, lat, busyCycles, dbz);
        check("mult busy cycles", 64'(busyCycles), 64'd33);
        check("mult -3*7", {bus.Hi, bus.Lo}, {32'hFFFFFFFF, 32'hFFFFFFEB});
        check("mult done busy", 64'(bus.Busy), 64'd0);
        checkOp("mult minmin", 2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0);
        checkOp("div -7/2", 2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        checkOp("div 7/-2", 2'b11, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0);
        checkOp("divu 100/7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        checkOp("divu by0", 2'b10, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF, 1'b1);
        checkOp("div by0 neg", 2'b11, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1);
        checkOp("div ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
        @(negedge Clk);
        check("dbz one cycle", 64'(bus.DivByZero), 64'd0);
        check("done one cycle", 64'(bus.Done), 64'd0);

        // Mid-op Start with different operands must not disturb the running op.
        bus.Start = 1'b1;
        bus.Op = 2'b00;
        bus.OperandA = 32'd6;
        bus.OperandB = 32'd7;
        @(negedge Clk);
        bus.Start = 1'b0;
        repeat (5) @(negedge Clk);
        bus.Start = 1'b1;
        bus.Op = 2'b10;
        bus.OperandA = 32'd1000;
        bus.OperandB = 32'd3;
        lat = 6;
        while (lat < 100) begin
            @(negedge Clk);
            bus.Start = 1'b0;
            lat++;
            if (bus.Done) break;
        end
        check("ignored start latency", 64'(lat), 64'd34);
        check("ignored start result", {bus.Hi, bus.Lo}, {32'd0, 32'd42});
        checkOp("back to back", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

        // Reset during iteration aborts the op and clears HI/LO.
        bus.Start = 1'b1;
        bus.Op = 2'b00;
        bus.OperandA = 32'd5;
        bus.OperandB = 32'd5;
        @(negedge Clk);
        bus.Start = 1'b0;
        repeat (10) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("abort busy", 64'(bus.Busy), 64'd0);
        check("abort hilo", {bus.Hi, bus.Lo}, 64'd0);
        doneSeen = 0;
        repeat (40) begin
            @(negedge Clk);
            if (bus.Done || bus.Busy) doneSeen++;
        end
        check("abort no done", 64'(doneSeen), 64'd0);

        // HI/LO writes are dropped while busy, taken while idle.
        bus.Start = 1'b1;
        bus.Op = 2'b00;
        bus.OperandA = 32'd2;
        bus.OperandB = 32'd3;
        @(negedge Clk);
        bus.Start = 1'b0;
        bus.HiWrite = 1'b1;
        bus.LoWrite = 1'b1;
        bus.HiLoData = 32'hDEAD;
        @(negedge Clk);
        bus.HiWrite = 1'b0;
        bus.LoWrite = 1'b0;
        check("write while busy", {bus.Hi, bus.Lo}, 64'd0);
        lat = 0;
        while (lat < 100 && !bus.Done) begin
            @(negedge Clk);
            lat++;
        end
        check("busy write op", {bus.Hi, bus.Lo}, {32'd0, 32'd6});
        bus.HiWrite = 1'b1;
        bus.HiLoData = 32'hABCD;
        @(negedge Clk);
        bus.HiWrite = 1'b0;
        check("mthi idle", {bus.Hi, bus.Lo}, {32'hABCD, 32'd6});
        bus.HiWrite = 1'b1;
        bus.LoWrite = 1'b1;
        bus.HiLoData = 32'h1357;
        @(negedge Clk);
        bus.HiWrite = 1'b0;
        bus.LoWrite = 1'b0;
        check("mthi mtlo both", {bus.Hi, bus.Lo}, {32'h1357, 32'h1357});

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end
endmodule
